// File: rtl/pipo_share_ctrl_pkg.sv
// Shared definitions for the pipo_reg access controller: FSM encoding,
// default data width and a constant clog2 helper.
package pipo_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Returns at least 1 so that index and counter vectors never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipo_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ (rotate, priority-encode, un-rotate).
module pipo_rr_pick
  import pipo_ctrl_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  localparam logic [PW:0] N_L = (PW+1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [PW-1:0]    idx;
  logic [PW:0]      sum;

  // rot[i] = req[(i + ptr) mod N_REQ]
  assign rot   = N_REQ'({req, req} >> ptr);
  assign valid = |req;

  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = PW'(i);
    end
  end

  assign sum    = {1'b0, idx} + {1'b0, ptr};
  assign winner = (sum >= N_L) ? PW'(sum - N_L) : PW'(sum);

endmodule

// File: rtl/pipo_share_ctrl.sv
// Round-robin owner of a shared pipo_reg: latches the winner's data onto pi,
// holds the grant for HOLD_CYCLES, then pulses ack for one cycle.
module pipo_share_ctrl
  import pipo_ctrl_pkg::*;
#(
  parameter int  N_REQ       = 4,
  parameter int  WIDTH       = DEFAULT_WIDTH,
  parameter int  HOLD_CYCLES = 2,
  localparam int PW          = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic                   ack,
  output logic [PW-1:0]          owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       pi_drv
);

  localparam int             CW       = clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [PW:0]    N_L      = (PW+1)'(N_REQ);

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [PW-1:0]    ptr_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             ack_reg;
  logic             busy_reg;
  logic [PW-1:0]    owner_reg;
  logic [WIDTH-1:0] pi_reg;

  logic [WIDTH-1:0] din_arr [N_REQ];
  logic [PW-1:0]    winner;
  logic             valid;
  logic [PW:0]      ptr_inc;
  logic [PW-1:0]    ptr_next;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign din_arr[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  pipo_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (winner),
    .valid  (valid)
  );

  assign ptr_inc  = {1'b0, winner} + (PW+1)'(1);
  assign ptr_next = (ptr_inc >= N_L) ? '0 : PW'(ptr_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      owner_reg <= '0;
      pi_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid) begin
            state_reg <= ST_HOLD;
            gnt_reg   <= N_REQ'(1) << winner;
            owner_reg <= winner;
            pi_reg    <= din_arr[winner];
            cnt_reg   <= CNT_LOAD;
            busy_reg  <= 1'b1;
            ptr_reg   <= ptr_next;
          end
        end
        // req may drop here; the transfer always runs to its ack.
        ST_HOLD: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            state_reg <= ST_ACK;
            ack_reg   <= 1'b1;
          end
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          gnt_reg   <= '0;
          ack_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign ack    = ack_reg;
  assign owner  = owner_reg;
  assign busy   = busy_reg;
  assign pi_drv = pi_reg;

endmodule

// File: tb/tb_pipo_share_ctrl.sv
// Directed bench for pipo_share_ctrl with a behavioural pipo_reg on pi_drv:
// a vector table of back-to-back transfers plus hand-written corner sequences.
module tb_pipo_share_ctrl;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int HOLD  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din;
  logic [3:0]  gnt;
  logic        ack;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  pi_drv;
  logic [3:0]  po;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_owner;
    logic [3:0]  exp_po;
  } vec_t;

  vec_t vecs [10];

  pipo_share_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .din    (din),
    .gnt    (gnt),
    .ack    (ack),
    .owner  (owner),
    .busy   (busy),
    .pi_drv (pi_drv)
  );

  always #5 clk = ~clk;

  // Stand-in for pipo_reg: loads pi every cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) po <= '0;
    else     po <= pi_drv;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge. Drives r/d, expects a grant at the next edge (k),
  // switches to mr/md after k, to nr/nd once ack is seen.
  task automatic xfer(input string tag,
                      input logic [3:0] r,  input logic [15:0] d,
                      input logic [3:0] mr, input logic [15:0] md,
                      input logic [3:0] nr, input logic [15:0] nd,
                      input logic [3:0] eg, input logic [1:0] eo, input logic [3:0] ep);
    int waits;
    req = r;
    din = d;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (gnt == '0 && waits < 8);
    chk({tag, ":grant_latency"}, waits, 1);
    chk({tag, ":gnt_k"}, gnt, eg);
    chk({tag, ":owner_k"}, owner, eo);
    chk({tag, ":pi_drv_k"}, pi_drv, ep);
    chk({tag, ":busy_k"}, busy, 1'b1);
    chk({tag, ":ack_k"}, ack, 1'b0);
    req = mr;
    din = md;
    @(negedge clk);
    chk({tag, ":po_k1"}, po, ep);
    chk({tag, ":ack_k1"}, ack, 1'b0);
    chk({tag, ":gnt_k1"}, gnt, eg);
    @(negedge clk);
    chk({tag, ":ack_k2"}, ack, 1'b1);
    chk({tag, ":gnt_k2"}, gnt, eg);
    chk({tag, ":pi_drv_k2"}, pi_drv, ep);
    req = nr;
    din = nd;
    @(negedge clk);
    chk({tag, ":ack_k3"}, ack, 1'b0);
    chk({tag, ":gnt_k3"}, gnt, 4'b0000);
    chk({tag, ":busy_k3"}, busy, 1'b0);
    $display("xfer %s gnt=%b owner=%0d po=%h", tag, eg, eo, po);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Pointer starts at 0 after reset.
    vecs[0] = '{4'b1111, 16'h4321, 4'b0001, 2'd0, 4'h1};
    vecs[1] = '{4'b1111, 16'h4321, 4'b0010, 2'd1, 4'h2};
    vecs[2] = '{4'b1111, 16'h4321, 4'b0100, 2'd2, 4'h3};
    vecs[3] = '{4'b1111, 16'h4321, 4'b1000, 2'd3, 4'h4};
    vecs[4] = '{4'b1111, 16'h4321, 4'b0001, 2'd0, 4'h1};
    vecs[5] = '{4'b0100, 16'h0500, 4'b0100, 2'd2, 4'h5};
    vecs[6] = '{4'b1001, 16'h9ABC, 4'b1000, 2'd3, 4'h9};
    vecs[7] = '{4'b1001, 16'h9ABC, 4'b0001, 2'd0, 4'hC};
    vecs[8] = '{4'b0001, 16'h000A, 4'b0001, 2'd0, 4'hA};
    vecs[9] = '{4'b0010, 16'h0070, 4'b0010, 2'd1, 4'h7};

    rst = 1'b1;
    req = '0;
    din = '0;
    repeat (2) @(negedge clk);
    chk("reset:gnt", gnt, 4'b0000);
    chk("reset:ack", ack, 1'b0);
    chk("reset:busy", busy, 1'b0);
    chk("reset:owner", owner, 2'd0);
    chk("reset:pi_drv", pi_drv, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      logic [3:0]  nr;
      logic [15:0] nd;
      nr = (i < 9) ? vecs[i+1].req : 4'b0000;
      nd = (i < 9) ? vecs[i+1].din : vecs[i].din;
      xfer($sformatf("vec%0d", i), vecs[i].req, vecs[i].din, vecs[i].req, vecs[i].din,
           nr, nd, vecs[i].exp_gnt, vecs[i].exp_owner, vecs[i].exp_po);
    end

    // Idle stability after the 0111 transfer.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d:pi_drv", c), pi_drv, 4'h7);
      chk($sformatf("idle%0d:po", c), po, 4'h7);
      chk($sformatf("idle%0d:gnt", c), gnt, 4'b0000);
      chk($sformatf("idle%0d:busy", c), busy, 1'b0);
    end
    $display("xfer idle pi_drv=%h po=%h", pi_drv, po);

    // req and din change right after the grant; captured data must stick.
    xfer("midchange", 4'b0010, 16'h00F0, 4'b0000, 16'h0000, 4'b0000, 16'h0000,
         4'b0010, 2'd1, 4'hF);

    // Asynchronous reset during HOLD.
    req = 4'b0010;
    din = 16'h0030;
    @(negedge clk);
    chk("rstmid:gnt_k", gnt, 4'b0010);
    chk("rstmid:pi_drv_k", pi_drv, 4'h3);
    req = 4'b0000;
    @(negedge clk);
    chk("rstmid:busy_hold", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid:gnt", gnt, 4'b0000);
    chk("rstmid:ack", ack, 1'b0);
    chk("rstmid:pi_drv", pi_drv, 4'h0);
    chk("rstmid:busy", busy, 1'b0);
    chk("rstmid:owner", owner, 2'd0);
    #1 rst = 1'b0;
    $display("xfer reset_mid gnt=%b busy=%b pi_drv=%h", gnt, busy, pi_drv);
    @(negedge clk);
    chk("rstmid:no_ack_after", ack, 1'b0);
    xfer("postreset", 4'b0100, 16'h0600, 4'b0100, 16'h0600, 4'b0000, 16'h0600,
         4'b0100, 2'd2, 4'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
